ssg_bus_arbiter: RTL and testbench
==================================

# ssg_bus_arbiter

Shares the I/O bus of `ssg_inst` between the host (cartridge-side CPU I/O cycles) and an internal register-write requester such as a playback engine or a reset-time initialiser. Sequencer writes arrive as {register, data} pairs and are queued in a small FIFO. Each pair is issued as an atomic A0-then-A1 write pair, after which the host's last register-latch value is restored. This keeps the host's view of the PSG address latch intact. The block sits directly in front of `ssg_inst`, and all PSG bus traffic passes through it.

## Interface
Parameters:
- `PORT_BASE`, 8'hA0: PSG address-latch port; the data port is `PORT_BASE+1`.
- `FIFO_DEPTH`, 4: sequencer queue entries; must be a power of 2.
- `TIMEOUT`, 5: cycles without `ssg_ack` before a sequencer-issued transaction is abandoned.

Ports:
- `reset` in 1: asynchronous, active-high.
- `clk` in 1: system clock (85.90908 MHz).
- `host_io_req` in 1, `host_wrt` in 1, `host_address` in 16, `host_wdata` in 8: host request.
- `host_ack` out 1, `host_rdata` out 8, `host_rdata_en` out 1: host response.
- `seq_valid` in 1, `seq_reg` in 4, `seq_data` in 8: sequencer write request.
- `seq_ready` out 1: FIFO not full.
- `ssg_io_req` out 1, `ssg_wrt` out 1, `ssg_address` out 16, `ssg_wdata` out 8: to `ssg_inst`.
- `ssg_ack` in 1, `ssg_rdata` in 8, `ssg_rdata_en` in 1: from `ssg_inst`.
- `err_timeout` out 1: sticky; set on any sequencer timeout; cleared only by reset.

## Operation
- **FIFO push.** A push happens on a cycle where `seq_valid && seq_ready`. `seq_ready = !full`, and it is 0 while `reset` is asserted. Push and pop in the same cycle are legal.
- **Shadow latch.** `shadow[7:0]` plus `shadow_valid` (both 0 at reset).
  - They are updated on a forwarded host write with `host_address[7:0]==PORT_BASE` in the cycle `ssg_ack` is high.
  - Only `host_address[7:0]` is decoded.
- **States:** IDLE, HOST, SEQ_A, SEQ_D, RESTORE, GAP.
- **IDLE arbitration.**
  - If only `host_io_req` is pending, go to HOST. If only the FIFO is non-empty, go to SEQ_A.
  - If both are pending, grant the party that did not win the previous grant (round-robin; the host wins the first tie after reset).
- **HOST.** Combinational pass-through of all four request signals to `ssg_*`.
  - `host_ack = ssg_ack`.
  - When `host_io_req` is seen low, go to IDLE. The host may abandon a request without waiting for ack; there is no arbiter timeout in HOST.
- **SEQ_A.** Drive a write of `{4'd0, reg}` to `PORT_BASE`, then go to GAP, then SEQ_D.
- **SEQ_D.** Drive a write of `data` to `PORT_BASE+1`, popping the FIFO head on completion. Then go to GAP, then RESTORE if `shadow_valid`, else IDLE.
- **RESTORE.** Drive a write of `shadow` to `PORT_BASE`, then go to GAP, then IDLE.
- **Sequencer transaction.**
  - `ssg_io_req=1` and `ssg_wrt=1`, with address and data held stable until `ssg_ack` is sampled high or TIMEOUT cycles elapse.
  - On timeout, set `err_timeout` and still advance: an SEQ_A timeout still proceeds to SEQ_D, so the FIFO never deadlocks.
- **GAP.** One cycle with `ssg_io_req=0`, `ssg_wrt=0`, `ssg_address=0`, `ssg_wdata=0`.
- **Host during sequencer states.** `host_ack=0`; the host keeps holding its request and is granted at the next IDLE.
- **Read path.** `host_rdata = ssg_rdata` always. `host_rdata_en = ssg_rdata_en && state==HOST`.

## Timing
- **Reset values.**
  - `ssg_io_req`, `ssg_wrt`, `ssg_address`, `ssg_wdata`: 0 (registered in sequencer states).
  - `host_ack`: 0.
  - `seq_ready`: 0 during reset, 1 on the first cycle after.
  - `err_timeout`: 0.
  - FIFO empty, state IDLE.
- **Latencies.**
  - Host request seen in IDLE: forwarded from the next cycle (1-cycle grant latency).
  - FIFO non-empty in IDLE: `ssg_io_req` rises on the next cycle.
  - Minimum sequencer pair with immediate acks: SEQ_A(1) + GAP + SEQ_D(1) + GAP + RESTORE(1) + GAP = 6 cycles back to IDLE.
- **Timeout.** `ssg_io_req` is held for exactly TIMEOUT cycles, then GAP.
- **Reset mid-transaction.** All outputs drop asynchronously, the FIFO is flushed and the shadow is cleared.

## Structure
- Package `ssg_bus_pkg`: state enum, `SSG_ADDR_OFS=0`, `SSG_DATA_OFS=1`, and the `{reg, data}` FIFO entry struct.
- One sub-module, `ssg_req_fifo`: synchronous FIFO with parameterised depth and width, exposing full/empty flags.
- The arbiter FSM, timeout counter and shadow register live in the top module.

## Test plan
- **Host write pass-through:** host writes A0<=7 then A1<=0xBE with `ssg_inst` acking. Expect each forwarded one cycle after the request, `host_ack` mirroring `ssg_ack`, and shadow=7.
- **Sequencer pair with restore:** shadow=7, then push {8, 0x0F}. Expect on the PSG bus A0<=8, A1<=0x0F, A0<=7, each separated by one idle cycle, then IDLE.
- **Conflict:** host requests A1 write during SEQ_D. Expect `host_ack` held 0 until RESTORE+GAP complete. The host write then lands after A0<=7, so PSG register 7 receives the host data.
- **FIFO full:** push 4 entries in 4 cycles while the host holds the bus. Expect `seq_ready`=0 after the 4th push, and all 4 pairs emitted in order once the host releases.
- **Timeout:** `ssg_ack` tied 0, push {0, 2}. Expect `ssg_io_req` high for 5 cycles per transaction, `err_timeout`=1, the FIFO drains, and the FSM returns to IDLE.
- **Async reset during SEQ_D:** expect all `ssg_*` outputs 0 immediately, FIFO empty, and `shadow_valid`=0 after release.

Source files
------------

// File: rtl/ssg_bus_pkg.sv
// Shared types and constants for the PSG bus arbiter.
// The FIFO entry carries one sequencer register write.
package ssg_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST,
        ST_SEQ_A,
        ST_SEQ_D,
        ST_RESTORE,
        ST_GAP
    } state_t;

    localparam logic [7:0] SSG_ADDR_OFS = 8'd0;
    localparam logic [7:0] SSG_DATA_OFS = 8'd1;

    typedef struct packed {
        logic [3:0] reg_num;
        logic [7:0] data;
    } seq_entry_t;

    localparam int SEQ_ENTRY_W = $bits(seq_entry_t);

endpackage

// File: rtl/ssg_req_fifo.sv
// Small synchronous show-ahead FIFO holding pending sequencer writes.
// The head entry is visible without a pop so the arbiter can load it directly.
module ssg_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssg_bus_arbiter.sv
// Shares the ssg_inst I/O bus between the host and a queued register-write sequencer.
// Sequencer writes go out as A0/A1 pairs, then the host's address latch is restored.
module ssg_bus_arbiter
    import ssg_bus_pkg::*;
#(
    parameter logic [7:0] PORT_BASE  = 8'hA0,
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 5
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        host_io_req,
    input  logic        host_wrt,
    input  logic [15:0] host_address,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_rdata_en,
    input  logic        seq_valid,
    input  logic [3:0]  seq_reg,
    input  logic [7:0]  seq_data,
    output logic        seq_ready,
    output logic        ssg_io_req,
    output logic        ssg_wrt,
    output logic [15:0] ssg_address,
    output logic [7:0]  ssg_wdata,
    input  logic        ssg_ack,
    input  logic [7:0]  ssg_rdata,
    input  logic        ssg_rdata_en,
    output logic        err_timeout
);

    localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT - 1);

    state_t         state_reg, state_next;
    state_t         after_gap_reg, after_gap_next;
    logic           bus_req_reg, bus_req_next;
    logic [7:0]     bus_addr_reg, bus_addr_next;
    logic [7:0]     bus_wdata_reg, bus_wdata_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic           last_seq_reg, last_seq_next;
    logic           err_reg, err_next;
    logic [7:0]     shadow_reg;
    logic           shadow_valid_reg;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           xfer_done;
    seq_entry_t     fifo_din;
    seq_entry_t     fifo_head;

    assign seq_ready = !fifo_full && !reset;
    assign fifo_din  = '{reg_num: seq_reg, data: seq_data};

    ssg_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SEQ_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (seq_valid && seq_ready),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next     = state_reg;
        after_gap_next = after_gap_reg;
        bus_req_next   = bus_req_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        timer_next     = timer_reg;
        last_seq_next  = last_seq_reg;
        err_next       = err_reg;
        fifo_pop       = 1'b0;
        xfer_done      = ssg_ack || (timer_reg == TIMER_MAX);
        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                // Round-robin on a tie: last_seq_reg starts at 1 so the host wins first.
                if (host_io_req && (fifo_empty || last_seq_reg)) begin
                    state_next    = ST_HOST;
                    last_seq_next = 1'b0;
                end else if (!fifo_empty) begin
                    state_next     = ST_SEQ_A;
                    last_seq_next  = 1'b1;
                    bus_req_next   = 1'b1;
                    bus_addr_next  = PORT_BASE + SSG_ADDR_OFS;
                    bus_wdata_next = {4'd0, fifo_head.reg_num};
                end
            end
            ST_HOST: begin
                if (!host_io_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEQ_A, ST_SEQ_D, ST_RESTORE: begin
                if (xfer_done) begin
                    state_next     = ST_GAP;
                    bus_req_next   = 1'b0;
                    bus_addr_next  = '0;
                    bus_wdata_next = '0;
                    timer_next     = '0;
                    if (!ssg_ack) begin
                        err_next = 1'b1;
                    end
                    case (state_reg)
                        ST_SEQ_A: after_gap_next = ST_SEQ_D;
                        ST_SEQ_D: begin
                            fifo_pop       = 1'b1;
                            after_gap_next = shadow_valid_reg ? ST_RESTORE : ST_IDLE;
                        end
                        default:  after_gap_next = ST_IDLE;
                    endcase
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            ST_GAP: begin
                state_next = after_gap_reg;
                if (after_gap_reg == ST_SEQ_D) begin
                    bus_req_next   = 1'b1;
                    bus_addr_next  = PORT_BASE + SSG_DATA_OFS;
                    bus_wdata_next = fifo_head.data;
                end else if (after_gap_reg == ST_RESTORE) begin
                    bus_req_next   = 1'b1;
                    bus_addr_next  = PORT_BASE + SSG_ADDR_OFS;
                    bus_wdata_next = shadow_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            after_gap_reg <= ST_IDLE;
            bus_req_reg   <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            timer_reg     <= '0;
            last_seq_reg  <= 1'b1;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            after_gap_reg <= after_gap_next;
            bus_req_reg   <= bus_req_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            timer_reg     <= timer_next;
            last_seq_reg  <= last_seq_next;
            err_reg       <= err_next;
        end
    end

    // Track the host's view of the address latch so it can be put back after a pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg       <= '0;
            shadow_valid_reg <= 1'b0;
        end else if (state_reg == ST_HOST && host_io_req && host_wrt && ssg_ack &&
                     host_address[7:0] == PORT_BASE + SSG_ADDR_OFS) begin
            shadow_reg       <= host_wdata;
            shadow_valid_reg <= 1'b1;
        end
    end

    always_comb begin
        if (state_reg == ST_HOST) begin
            ssg_io_req  = host_io_req;
            ssg_wrt     = host_wrt;
            ssg_address = host_address;
            ssg_wdata   = host_wdata;
        end else begin
            ssg_io_req  = bus_req_reg;
            ssg_wrt     = bus_req_reg;
            ssg_address = {8'h00, bus_addr_reg};
            ssg_wdata   = bus_wdata_reg;
        end
    end

    assign host_ack      = (state_reg == ST_HOST) && ssg_ack;
    assign host_rdata    = ssg_rdata;
    assign host_rdata_en = ssg_rdata_en && (state_reg == ST_HOST);
    assign err_timeout   = err_reg;

endmodule

// File: tb/tb_ssg_bus_arbiter.sv
// Bench for ssg_bus_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-script model of bus ownership.
module tb_ssg_bus_arbiter;

    localparam logic [7:0] PB      = 8'hA0;
    localparam int         DEPTH   = 4;
    localparam int         TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_io_req, host_wrt;
    logic [15:0] host_address;
    logic [7:0]  host_wdata;
    logic        host_ack, host_rdata_en;
    logic [7:0]  host_rdata;
    logic        seq_valid;
    logic [3:0]  seq_reg;
    logic [7:0]  seq_data;
    logic        seq_ready;
    logic        ssg_io_req, ssg_wrt;
    logic [15:0] ssg_address;
    logic [7:0]  ssg_wdata;
    logic        ssg_ack, ssg_rdata_en;
    logic [7:0]  ssg_rdata;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    ssg_bus_arbiter dut (
        .reset         (reset),
        .clk           (clk),
        .host_io_req   (host_io_req),
        .host_wrt      (host_wrt),
        .host_address  (host_address),
        .host_wdata    (host_wdata),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .host_rdata_en (host_rdata_en),
        .seq_valid     (seq_valid),
        .seq_reg       (seq_reg),
        .seq_data      (seq_data),
        .seq_ready     (seq_ready),
        .ssg_io_req    (ssg_io_req),
        .ssg_wrt       (ssg_wrt),
        .ssg_address   (ssg_address),
        .ssg_wdata     (ssg_wdata),
        .ssg_ack       (ssg_ack),
        .ssg_rdata     (ssg_rdata),
        .ssg_rdata_en  (ssg_rdata_en),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: who owns the bus, and for the sequencer a script of {addr8,data8} writes.
    typedef enum int { M_IDLE, M_HOST, M_SEQ } mode_t;
    mode_t       m_mode;
    logic [11:0] m_q[$];
    logic [15:0] m_script[$];
    logic [7:0]  m_shadow;
    bit          m_shadow_valid, m_err, m_last_seq, m_gap;
    int          m_cnt, m_idx;
    logic [23:0] wlog[$];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_script.delete();
        m_shadow = 8'h00;
        m_shadow_valid = 0;
        m_err = 0;
        m_last_seq = 1;
        m_gap = 0;
        m_cnt = 0;
        m_idx = 0;
    endtask

    always @(negedge clk) begin : cmp
        logic        e_req, e_wrt, e_hack, e_rden, do_push, pre_full;
        logic [15:0] e_addr, item;
        logic [7:0]  e_wdata;
        if (reset) begin
            chk("rst_ssg_io_req", ssg_io_req, 0);
            chk("rst_ssg_wrt", ssg_wrt, 0);
            chk("rst_ssg_address", ssg_address, 0);
            chk("rst_ssg_wdata", ssg_wdata, 0);
            chk("rst_host_ack", host_ack, 0);
            chk("rst_seq_ready", seq_ready, 0);
            chk("rst_err_timeout", err_timeout, 0);
            model_reset();
        end else begin
            e_req = 0; e_wrt = 0; e_addr = 16'h0; e_wdata = 8'h0; e_hack = 0; e_rden = 0;
            case (m_mode)
                M_HOST: begin
                    e_req = host_io_req; e_wrt = host_wrt; e_addr = host_address;
                    e_wdata = host_wdata; e_hack = ssg_ack; e_rden = ssg_rdata_en;
                end
                M_SEQ: begin
                    if (!m_gap) begin
                        item = m_script[0];
                        e_req = 1; e_wrt = 1; e_addr = {8'h00, item[15:8]}; e_wdata = item[7:0];
                    end
                end
                default: ;
            endcase
            chk("ssg_io_req", ssg_io_req, e_req);
            chk("ssg_wrt", ssg_wrt, e_wrt);
            chk("ssg_address", ssg_address, e_addr);
            chk("ssg_wdata", ssg_wdata, e_wdata);
            chk("host_ack", host_ack, e_hack);
            chk("host_rdata_en", host_rdata_en, e_rden);
            chk("host_rdata", host_rdata, ssg_rdata);
            chk("seq_ready", seq_ready, (m_q.size() < DEPTH));
            chk("err_timeout", err_timeout, m_err);
            if (ssg_io_req && ssg_wrt && ssg_ack) wlog.push_back({ssg_address, ssg_wdata});

            // advance to what the coming rising edge does
            pre_full = (m_q.size() >= DEPTH);
            do_push  = seq_valid && !pre_full;
            case (m_mode)
                M_IDLE: begin
                    if (host_io_req && (m_q.size() == 0 || m_last_seq)) begin
                        m_mode = M_HOST; m_last_seq = 0;
                    end else if (m_q.size() != 0) begin
                        m_mode = M_SEQ; m_last_seq = 1; m_gap = 0; m_cnt = 0; m_idx = 0;
                        m_script.delete();
                        m_script.push_back({PB, 4'h0, m_q[0][11:8]});
                        m_script.push_back({PB + 8'd1, m_q[0][7:0]});
                        if (m_shadow_valid) m_script.push_back({PB, m_shadow});
                    end
                end
                M_HOST: begin
                    if (host_io_req && host_wrt && ssg_ack && host_address[7:0] == PB) begin
                        m_shadow = host_wdata; m_shadow_valid = 1;
                    end
                    if (!host_io_req) m_mode = M_IDLE;
                end
                default: begin
                    if (m_gap) begin
                        m_gap = 0;
                        if (m_script.size() == 0) m_mode = M_IDLE;
                    end else if (ssg_ack || m_cnt == TIMEOUT - 1) begin
                        if (!ssg_ack) m_err = 1;
                        if (m_idx == 1) void'(m_q.pop_front());
                        void'(m_script.pop_front());
                        m_idx++; m_cnt = 0; m_gap = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            if (do_push) m_q.push_back({seq_reg, seq_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d, output int n);
        logic got;
        host_io_req = 1; host_wrt = 1; host_address = a; host_wdata = d;
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(negedge clk); got = host_ack; n++;
            cyc();
        end
        chk("host_write_ack", got, 1);
        host_io_req = 0; host_wrt = 0;
        cyc();
    endtask

    task automatic push(input logic [3:0] r, input logic [7:0] d);
        logic rdy;
        int   n;
        seq_valid = 1; seq_reg = r; seq_data = d; rdy = 0; n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk); rdy = seq_ready; n++;
            cyc();
        end
        chk("push_ready", rdy, 1);
        seq_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_log[$];
        logic        found, ack_seen, h_active;
        logic [31:0] rnd;
        int          n, cnt, lsz;

        reset = 1; host_io_req = 0; host_wrt = 0; host_address = 16'h0; host_wdata = 8'h0;
        seq_valid = 0; seq_reg = 4'h0; seq_data = 8'h0;
        ssg_ack = 0; ssg_rdata = 8'h0; ssg_rdata_en = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("post_reset_seq_ready", seq_ready, 1);
        chk("post_reset_io_req", ssg_io_req, 0);
        cyc();

        // host pass-through, then a sequencer pair with restore
        ssg_ack = 1;
        host_write(16'h00A0, 8'h07, n);
        chk("grant_latency_a0", n, 2);
        host_write(16'h00A1, 8'hBE, n);
        chk("grant_latency_a1", n, 2);
        push(4'h8, 8'h0F);
        repeat (10) cyc();
        exp_log = '{24'h00A007, 24'h00A1BE, 24'h00A008, 24'h00A10F, 24'h00A007};

        // FIFO fills while the host holds the bus
        ssg_ack = 0;
        host_io_req = 1; host_wrt = 0; host_address = 16'h1234;
        cyc(); cyc();
        for (int i = 1; i <= 4; i++) push(4'(i), 8'(i * 17));
        @(negedge clk);
        chk("fifo_full_ready", seq_ready, 0);
        cyc();
        host_io_req = 0; ssg_ack = 1;
        repeat (40) cyc();
        for (int i = 1; i <= 4; i++) begin
            exp_log.push_back({16'h00A0, 4'h0, 4'(i)});
            exp_log.push_back({16'h00A1, 8'(i * 17)});
            exp_log.push_back(24'h00A007);
        end

        // host A1 write arriving during the data phase waits for restore
        push(4'h5, 8'h66);
        found = 0; n = 0;
        while (!found && n < 40) begin
            @(negedge clk); found = ssg_io_req && (ssg_address == 16'h00A1); n++;
            cyc();
        end
        chk("conflict_saw_seq_d", found, 1);
        host_write(16'h00A1, 8'h99, n);
        chk("conflict_host_wait", n, 5);
        repeat (4) cyc();
        exp_log.push_back(24'h00A005);
        exp_log.push_back(24'h00A166);
        exp_log.push_back(24'h00A007);
        exp_log.push_back(24'h00A199);

        chk("log_size", wlog.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++)
            chk($sformatf("log_%0d", i), wlog[i], exp_log[i]);

        // timeout on every write of the pair and restore
        ssg_ack = 0;
        push(4'h0, 8'h02);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); if (ssg_io_req) cnt++;
            cyc();
        end
        chk("timeout_req_cycles", cnt, 15);
        chk("timeout_err", err_timeout, 1);

        // asynchronous reset in the data phase
        push(4'h3, 8'h55);
        found = 0; n = 0;
        while (!found && n < 40) begin
            @(negedge clk); found = ssg_io_req && (ssg_address == 16'h00A1); n++;
            if (!found) cyc();
        end
        chk("reset_saw_seq_d", found, 1);
        #2 reset = 1;
        #1;
        chk("async_io_req", ssg_io_req, 0);
        chk("async_wrt", ssg_wrt, 0);
        chk("async_address", ssg_address, 0);
        chk("async_wdata", ssg_wdata, 0);
        chk("async_seq_ready", seq_ready, 0);
        cyc(); cyc();
        reset = 0;
        @(negedge clk);
        chk("after_reset_err", err_timeout, 0);
        chk("after_reset_ready", seq_ready, 1);
        cyc();
        ssg_ack = 1;
        lsz = wlog.size();
        push(4'h9, 8'h33);
        repeat (12) cyc();
        chk("no_restore_count", wlog.size() - lsz, 2);
        if (wlog.size() >= lsz + 2) begin
            chk("no_restore_a0", wlog[lsz], 24'h00A009);
            chk("no_restore_a1", wlog[lsz + 1], 24'h00A133);
        end

        // random traffic
        h_active = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); ack_seen = host_ack;
            cyc();
            if (h_active) begin
                if (ack_seen || $urandom_range(0, 31) == 0) begin
                    h_active = 0; host_io_req = 0;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                h_active = 1; host_io_req = 1;
                host_wrt = 1'($urandom_range(0, 1));
                rnd = $urandom;
                case ($urandom_range(0, 3))
                    0: host_address = {rnd[15:8], PB};
                    1: host_address = {rnd[15:8], PB + 8'd1};
                    default: host_address = rnd[15:0];
                endcase
                host_wdata = rnd[23:16];
            end
            rnd = $urandom;
            seq_valid = ($urandom_range(0, 3) == 0);
            seq_reg = rnd[3:0];
            seq_data = rnd[11:4];
            ssg_rdata = rnd[19:12];
            ssg_rdata_en = rnd[20];
            if ((c / 200) % 3 == 2) ssg_ack = ($urandom_range(0, 15) == 0);
            else                    ssg_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1;
                cyc(); cyc();
                reset = 0;
            end
        end
        seq_valid = 0; host_io_req = 0;
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
